// File: rtl/mem_wb_stage_pkg.sv
// Shared core types: ALU ops, store widths, writeback result sources, load funct3 codes
// and the memory-stage handshake states.
package mem_wb_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10
  } store_type_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_fsm_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage bundle: EX/MEM inputs, data-memory handshake and regfile write port.
interface mem_wb_stage_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int PC_WIDTH        = 11,
  parameter int DMEM_ADDR_WIDTH = 10
);
  logic                       i_valid_m;
  logic                       i_regwrite_m;
  logic [1:0]                 i_resultsrc_m;
  logic                       i_memwrite_m;
  logic [1:0]                 i_storetype_m;
  logic [2:0]                 i_loadtype_m;
  logic [DATA_WIDTH-1:0]      i_alu_result_m;
  logic [DATA_WIDTH-1:0]      i_write_data_m;
  logic [ADDR_WIDTH-1:0]      i_rd_addr_m;
  logic [PC_WIDTH-1:0]        i_pc4_m;
  logic                       o_dmem_req;
  logic                       o_dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr;
  logic [DATA_WIDTH-1:0]      o_dmem_wdata;
  logic [3:0]                 o_dmem_be;
  logic                       i_dmem_ready;
  logic [DATA_WIDTH-1:0]      i_dmem_rdata;
  logic                       o_stall_m;
  logic                       o_reg_write_w;
  logic [ADDR_WIDTH-1:0]      o_rd_addr_w;
  logic [DATA_WIDTH-1:0]      o_result_w;

  modport master (
    output i_valid_m, i_regwrite_m, i_resultsrc_m, i_memwrite_m, i_storetype_m,
           i_loadtype_m, i_alu_result_m, i_write_data_m, i_rd_addr_m, i_pc4_m,
           i_dmem_ready, i_dmem_rdata,
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
           o_stall_m, o_reg_write_w, o_rd_addr_w, o_result_w
  );

  modport slave (
    input  i_valid_m, i_regwrite_m, i_resultsrc_m, i_memwrite_m, i_storetype_m,
           i_loadtype_m, i_alu_result_m, i_write_data_m, i_rd_addr_m, i_pc4_m,
           i_dmem_ready, i_dmem_rdata,
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
           o_stall_m, o_reg_write_w, o_rd_addr_w, o_result_w
  );
endinterface

// File: rtl/mem_wb_stage_load_store_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extract/extend.
module mem_wb_stage_load_store_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        memwrite,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (memwrite) begin
      case (store_type_t'(store_type))
        ST_BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        ST_HALF: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (load_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  load_data = {24'h0, byte_sel};
      LD_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage with integrated MEM/WB register: issues data-memory requests, stalls on
// slow memory, and drives the regfile write port one cycle after the access completes.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int PC_WIDTH        = 11,
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mem_wb_stage_if.slave bus
);
  mem_fsm_t              state_q, state_d;
  logic                  mem_access;
  logic                  stall;
  logic [3:0]            be;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;
  logic [DATA_WIDTH-1:0] result_m;

  assign mem_access = bus.i_valid_m & (bus.i_memwrite_m | (bus.i_resultsrc_m == RES_MEM));
  assign stall      = mem_access & ~bus.i_dmem_ready;

  // Gated by reset so an in-flight request is withdrawn the moment reset asserts.
  assign bus.o_dmem_req   = mem_access & i_rst_n;
  assign bus.o_stall_m    = stall & i_rst_n;
  assign bus.o_dmem_we    = bus.i_memwrite_m;
  assign bus.o_dmem_addr  = bus.i_alu_result_m[DMEM_ADDR_WIDTH+1:2];
  assign bus.o_dmem_wdata = st_wdata;
  assign bus.o_dmem_be    = be;

  mem_wb_stage_load_store_align u_align (
    .addr_lo    (bus.i_alu_result_m[1:0]),
    .memwrite   (bus.i_memwrite_m),
    .store_type (bus.i_storetype_m),
    .load_type  (bus.i_loadtype_m),
    .store_data (bus.i_write_data_m),
    .rdata      (bus.i_dmem_rdata),
    .be         (be),
    .wdata      (st_wdata),
    .load_data  (ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= MEM_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (mem_access && !bus.i_dmem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.i_dmem_ready)                state_d = MEM_IDLE;
      default:                                       state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    case (bus.i_resultsrc_m)
      RES_MEM: result_m = ld_data;
      RES_PC4: result_m = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, bus.i_pc4_m};
      default: result_m = bus.i_alu_result_m;
    endcase
  end

  // A stalled cycle pushes a bubble so the completing load writes exactly once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_reg_write_w <= 1'b0;
      bus.o_rd_addr_w   <= '0;
      bus.o_result_w    <= '0;
    end else if (stall) begin
      bus.o_reg_write_w <= 1'b0;
    end else begin
      bus.o_reg_write_w <= bus.i_regwrite_m & bus.i_valid_m;
      bus.o_rd_addr_w   <= bus.i_rd_addr_m;
      bus.o_result_w    <= result_m;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: stores, loads, wait states, PC+4 and reset.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic i_clk;
  logic i_rst_n;
  int   tests_run;
  int   tests_failed;

  mem_wb_stage_if bus_if ();

  mem_wb_stage dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [1:0] st, input logic [2:0] lt, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic [10:0] pc4,
                       input logic rdy, input logic [31:0] rdata);
    bus_if.i_valid_m      = v;
    bus_if.i_regwrite_m   = rw;
    bus_if.i_resultsrc_m  = rs;
    bus_if.i_memwrite_m   = mw;
    bus_if.i_storetype_m  = st;
    bus_if.i_loadtype_m   = lt;
    bus_if.i_alu_result_m = a;
    bus_if.i_write_data_m = d;
    bus_if.i_rd_addr_m    = rd;
    bus_if.i_pc4_m        = pc4;
    bus_if.i_dmem_ready   = rdy;
    bus_if.i_dmem_rdata   = rdata;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    // LW with memory not ready: request and stall must still be masked by reset
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LW, 32'h10, 32'h0, 5'd3, 11'h0, 0, 32'h0);
    #12;
    tests_run++;
    if (bus_if.o_dmem_req !== 1'b0 || bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req_stall: req=%b stall=%b expected 0 0", bus_if.o_dmem_req, bus_if.o_stall_m);
    end
    tests_run++;
    if (bus_if.o_reg_write_w !== 1'b0 || bus_if.o_rd_addr_w !== 5'd0 || bus_if.o_result_w !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_wb: we=%b rd=%0d res=%h expected 0 0 0",
               bus_if.o_reg_write_w, bus_if.o_rd_addr_w, bus_if.o_result_w);
    end
    drive(0, 0, RES_ALU, 0, ST_WORD, LD_LW, 32'h0, 32'h0, 5'd0, 11'h0, 0, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    @(posedge i_clk); #1;
    drive(1, 0, RES_ALU, 1, ST_WORD, LD_LW, 32'h104, 32'hDEADBEEF, 5'd0, 11'h0, 1, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_req !== 1'b1 || bus_if.o_dmem_we !== 1'b1 || bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_ctrl: req=%b we=%b stall=%b expected 1 1 0",
               bus_if.o_dmem_req, bus_if.o_dmem_we, bus_if.o_stall_m);
    end
    tests_run++;
    if (bus_if.o_dmem_addr !== 10'h041 || bus_if.o_dmem_be !== 4'b1111 || bus_if.o_dmem_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sw_lanes: addr=%h be=%b wdata=%h expected 041 1111 deadbeef",
               bus_if.o_dmem_addr, bus_if.o_dmem_be, bus_if.o_dmem_wdata);
    end
  endtask

  task automatic test_store_byte_half();
    @(posedge i_clk); #1;
    drive(1, 0, RES_ALU, 1, ST_BYTE, LD_LW, 32'h103, 32'h000000A5, 5'd0, 11'h0, 1, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_be !== 4'b1000 || bus_if.o_dmem_wdata !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL sb_lanes: be=%b wdata=%h expected 1000 a5a5a5a5", bus_if.o_dmem_be, bus_if.o_dmem_wdata);
    end
    @(posedge i_clk); #1;
    drive(1, 0, RES_ALU, 1, ST_HALF, LD_LW, 32'h102, 32'h00001234, 5'd0, 11'h0, 1, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_be !== 4'b1100 || bus_if.o_dmem_wdata !== 32'h12341234) begin
      tests_failed++;
      $display("FAIL sh_lanes: be=%b wdata=%h expected 1100 12341234", bus_if.o_dmem_be, bus_if.o_dmem_wdata);
    end
    @(posedge i_clk); #1;
    drive(1, 0, RES_ALU, 1, ST_BYTE, LD_LW, 32'h101, 32'h0000003C, 5'd0, 11'h0, 1, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_be !== 4'b0010 || bus_if.o_dmem_wdata !== 32'h3C3C3C3C) begin
      tests_failed++;
      $display("FAIL sb1_lanes: be=%b wdata=%h expected 0010 3c3c3c3c", bus_if.o_dmem_be, bus_if.o_dmem_wdata);
    end
  endtask

  task automatic test_load_extract();
    @(posedge i_clk); #1;
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LB, 32'h2, 32'h0, 5'd7, 11'h0, 1, 32'h0080FF00);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_we !== 1'b0 || bus_if.o_dmem_be !== 4'b1111 || bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb_req: we=%b be=%b stall=%b expected 0 1111 0",
               bus_if.o_dmem_we, bus_if.o_dmem_be, bus_if.o_stall_m);
    end
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_result_w !== 32'hFFFFFF80 || bus_if.o_reg_write_w !== 1'b1 || bus_if.o_rd_addr_w !== 5'd7) begin
      tests_failed++;
      $display("FAIL lb_wb: res=%h we=%b rd=%0d expected ffffff80 1 7",
               bus_if.o_result_w, bus_if.o_reg_write_w, bus_if.o_rd_addr_w);
    end
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LHU, 32'h2, 32'h0, 5'd8, 11'h0, 1, 32'h0080FF00);
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_result_w !== 32'h00000080 || bus_if.o_rd_addr_w !== 5'd8) begin
      tests_failed++;
      $display("FAIL lhu_wb: res=%h rd=%0d expected 00000080 8", bus_if.o_result_w, bus_if.o_rd_addr_w);
    end
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LH, 32'h0, 32'h0, 5'd9, 11'h0, 1, 32'h0080FF00);
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_result_w !== 32'hFFFFFF00) begin
      tests_failed++;
      $display("FAIL lh_wb: res=%h expected ffffff00", bus_if.o_result_w);
    end
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LBU, 32'h1, 32'h0, 5'd9, 11'h0, 1, 32'h0080FF00);
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_result_w !== 32'h000000FF) begin
      tests_failed++;
      $display("FAIL lbu_wb: res=%h expected 000000ff", bus_if.o_result_w);
    end
  endtask

  task automatic test_load_wait();
    @(posedge i_clk); #1;
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LW, 32'h10, 32'h0, 5'd5, 11'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      tests_run++;
      if (bus_if.o_stall_m !== 1'b1 || bus_if.o_dmem_req !== 1'b1 || bus_if.o_dmem_addr !== 10'h004) begin
        tests_failed++;
        $display("FAIL lw_wait_stall[%0d]: stall=%b req=%b addr=%h expected 1 1 004",
                 i, bus_if.o_stall_m, bus_if.o_dmem_req, bus_if.o_dmem_addr);
      end
      @(posedge i_clk); #1;
      tests_run++;
      if (bus_if.o_reg_write_w !== 1'b0 || dut.state_q !== MEM_WAIT) begin
        tests_failed++;
        $display("FAIL lw_wait_bubble[%0d]: we=%b state=%0d expected 0 1", i, bus_if.o_reg_write_w, dut.state_q);
      end
    end
    bus_if.i_dmem_ready = 1'b1;
    bus_if.i_dmem_rdata = 32'hCAFEF00D;
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_ready_stall: stall=%b expected 0", bus_if.o_stall_m);
    end
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_reg_write_w !== 1'b1 || bus_if.o_rd_addr_w !== 5'd5 || bus_if.o_result_w !== 32'hCAFEF00D
        || dut.state_q !== MEM_IDLE) begin
      tests_failed++;
      $display("FAIL lw_wait_wb: we=%b rd=%0d res=%h state=%0d expected 1 5 cafef00d 0",
               bus_if.o_reg_write_w, bus_if.o_rd_addr_w, bus_if.o_result_w, dut.state_q);
    end
    drive(0, 1, RES_MEM, 1, ST_WORD, LD_LW, 32'h10, 32'h0, 5'd5, 11'h0, 0, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_req !== 1'b0 || bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubble_req: req=%b stall=%b expected 0 0", bus_if.o_dmem_req, bus_if.o_stall_m);
    end
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_reg_write_w !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_single_write: we=%b expected 0", bus_if.o_reg_write_w);
    end
  endtask

  task automatic test_pc4();
    drive(1, 1, RES_PC4, 0, ST_WORD, LD_LW, 32'h55, 32'h0, 5'd1, 11'h01C, 0, 32'h0);
    @(negedge i_clk);
    tests_run++;
    if (bus_if.o_dmem_req !== 1'b0 || bus_if.o_stall_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL jal_req: req=%b stall=%b expected 0 0", bus_if.o_dmem_req, bus_if.o_stall_m);
    end
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_result_w !== 32'h0000001C || bus_if.o_reg_write_w !== 1'b1 || bus_if.o_rd_addr_w !== 5'd1) begin
      tests_failed++;
      $display("FAIL jal_wb: res=%h we=%b rd=%0d expected 0000001c 1 1",
               bus_if.o_result_w, bus_if.o_reg_write_w, bus_if.o_rd_addr_w);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LW, 32'h20, 32'h0, 5'd6, 11'h0, 0, 32'h0);
    @(posedge i_clk); #2;
    tests_run++;
    if (dut.state_q !== MEM_WAIT) begin
      tests_failed++;
      $display("FAIL rst_wait_entry: state=%0d expected 1", dut.state_q);
    end
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.o_dmem_req !== 1'b0 || bus_if.o_stall_m !== 1'b0 || bus_if.o_reg_write_w !== 1'b0
        || bus_if.o_result_w !== 32'h0 || bus_if.o_rd_addr_w !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_in_wait: req=%b stall=%b we=%b res=%h rd=%0d expected 0 0 0 0 0",
               bus_if.o_dmem_req, bus_if.o_stall_m, bus_if.o_reg_write_w, bus_if.o_result_w, bus_if.o_rd_addr_w);
    end
    drive(0, 0, RES_ALU, 0, ST_WORD, LD_LW, 32'h0, 32'h0, 5'd0, 11'h0, 0, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    tests_run++;
    if (dut.state_q !== MEM_IDLE) begin
      tests_failed++;
      $display("FAIL rst_release_state: state=%0d expected 0", dut.state_q);
    end
    drive(1, 1, RES_MEM, 0, ST_WORD, LD_LW, 32'h4, 32'h0, 5'd9, 11'h0, 1, 32'h11223344);
    @(posedge i_clk); #1;
    tests_run++;
    if (bus_if.o_reg_write_w !== 1'b1 || bus_if.o_rd_addr_w !== 5'd9 || bus_if.o_result_w !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL rst_fresh_lw: we=%b rd=%0d res=%h expected 1 9 11223344",
               bus_if.o_reg_write_w, bus_if.o_rd_addr_w, bus_if.o_result_w);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_load_extract();
    test_load_wait();
    test_pc4();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
